// File: rtl/gpr_ctrl.sv
// gpr_ctrl: 4-cycle MIPS R/I decode controller driving GPR addresses, ALU op and write strobe.
// Optional feature: define GPR_CTRL_TRAP_EN to stall acceptance permanently after an illegal instruction.
module gpr_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst,
    input  logic        inst_valid,
    output logic        inst_ready,
    output logic [4:0]  R_Addr_A,
    output logic [4:0]  R_Addr_B,
    output logic [4:0]  W_Addr,
    output logic        Write_Reg,
    output logic [2:0]  ALU_OP,
    output logic        rd_rt_s,
    output logic        rt_imm_s,
    output logic        imm_s,
    output logic        done,
    output logic        illegal,
    output logic [15:0] retired
);
    typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;
    state_t state, state_nx;
    logic [5:0] op, funct;
    logic [2:0] d_alu;
    logic d_ill, d_imm_s, d_rt, cur_ill, accept;
    assign op = inst[31:26];
    assign funct = inst[5:0];
`ifdef GPR_CTRL_TRAP_EN
    assign inst_ready = (state == IDLE) && !illegal;
`else
    assign inst_ready = (state == IDLE);
`endif
    assign accept = inst_valid && inst_ready;
    assign done = (state == WB);
    assign Write_Reg = done && (W_Addr != 5'd0) && !cur_ill;
    // decode the offered word; illegal encodings fall back to neutral selects
    always_comb begin
        d_alu = 3'b000;
        d_ill = 1'b0;
        d_imm_s = 1'b0;
        if (op == 6'h00) begin
            case (funct)
                6'h24: d_alu = 3'b000;
                6'h25: d_alu = 3'b001;
                6'h26: d_alu = 3'b010;
                6'h27: d_alu = 3'b011;
                6'h20: d_alu = 3'b100;
                6'h22: d_alu = 3'b101;
                6'h2A: d_alu = 3'b110;
                6'h04: d_alu = 3'b111;
                default: d_ill = 1'b1;
            endcase
        end else begin
            case (op)
                6'h08: begin d_alu = 3'b100; d_imm_s = 1'b1; end
                6'h0A: begin d_alu = 3'b110; d_imm_s = 1'b1; end
                6'h0C: d_alu = 3'b000;
                6'h0D: d_alu = 3'b001;
                6'h0E: d_alu = 3'b010;
                default: d_ill = 1'b1;
            endcase
        end
        d_rt = (op != 6'h00) && !d_ill;
    end
    // next-state: accept only from IDLE, then walk DECODE/EXEC/WB unconditionally
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? DECODE : IDLE;
            DECODE:  state_nx = EXEC;
            EXEC:    state_nx = WB;
            default: state_nx = IDLE;
        endcase
    end
    // state, decoded-output latch on acceptance, sticky illegal and retire counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            R_Addr_A <= 5'd0;
            R_Addr_B <= 5'd0;
            W_Addr   <= 5'd0;
            ALU_OP   <= 3'b000;
            rd_rt_s  <= 1'b0;
            rt_imm_s <= 1'b0;
            imm_s    <= 1'b0;
            cur_ill  <= 1'b0;
            illegal  <= 1'b0;
            retired  <= 16'd0;
        end else begin
            state <= state_nx;
            if (accept) begin
                R_Addr_A <= inst[25:21];
                R_Addr_B <= inst[20:16];
                W_Addr   <= d_rt ? inst[20:16] : inst[15:11];
                ALU_OP   <= d_alu;
                rd_rt_s  <= d_rt;
                rt_imm_s <= d_rt;
                imm_s    <= d_imm_s;
                cur_ill  <= d_ill;
                illegal  <= illegal | d_ill;
            end
            if (done)
                retired <= retired + 16'd1;
        end
    end
endmodule

// File: tb/tb_gpr_ctrl.sv
// tb_gpr_ctrl: scoreboard bench; stimulus queues expected WB results, a monitor checks each done pulse.
module tb_gpr_ctrl;
    logic clk = 1'b0, rst, inst_valid, inst_ready, Write_Reg, rd_rt_s, rt_imm_s, imm_s, done, illegal;
    logic [31:0] inst;
    logic [4:0] R_Addr_A, R_Addr_B, W_Addr;
    logic [2:0] ALU_OP;
    logic [15:0] retired;
    int pass = 0, total = 0;
    logic [15:0] exp_ret = 16'd0;
    typedef struct {
        logic [4:0] ra, rb, wa;
        logic wr;
        logic [2:0] alu;
        logic rt, ri, is;
        logic [15:0] ret;
        bit full;
    } exp_t;
    exp_t q[$];

    gpr_ctrl dut (
        .clk(clk), .rst(rst), .inst(inst), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .R_Addr_A(R_Addr_A), .R_Addr_B(R_Addr_B), .W_Addr(W_Addr), .Write_Reg(Write_Reg),
        .ALU_OP(ALU_OP), .rd_rt_s(rd_rt_s), .rt_imm_s(rt_imm_s), .imm_s(imm_s),
        .done(done), .illegal(illegal), .retired(retired)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        total++;
        if (act === req) pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endfunction

    function automatic exp_t mk(logic [4:0] ra, logic [4:0] rb, logic [4:0] wa, logic wr,
                                logic [2:0] alu, logic rt, logic ri, logic is, bit full);
        exp_t e;
        e.ra = ra; e.rb = rb; e.wa = wa; e.wr = wr; e.alu = alu;
        e.rt = rt; e.ri = ri; e.is = is; e.ret = 16'd0; e.full = full;
        return e;
    endfunction

    // called at a negedge; returns at the negedge inside DECODE
    task automatic issue(input logic [31:0] w, input exp_t e, input bit push);
        int n = 0;
        while (inst_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n == 20) chk("ready_timeout", 32'(inst_ready), 32'd1);
        inst = w;
        inst_valid = 1'b1;
        if (push) begin
            e.ret = exp_ret;
            q.push_back(e);
            exp_ret++;
        end
        @(negedge clk);
        inst_valid = 1'b0;
        inst = $urandom;
    endtask

    task automatic chk_reset();
        chk("rst_ready", 32'(inst_ready), 32'd1);
        chk("rst_ra", 32'(R_Addr_A), 32'd0);
        chk("rst_rb", 32'(R_Addr_B), 32'd0);
        chk("rst_wa", 32'(W_Addr), 32'd0);
        chk("rst_alu", 32'(ALU_OP), 32'd0);
        chk("rst_sel", 32'({rd_rt_s, rt_imm_s, imm_s}), 32'd0);
        chk("rst_wr_done", 32'({Write_Reg, done}), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_retired", 32'(retired), 32'd0);
    endtask

    // monitor: every done pulse pops one expectation; writes without done are errors
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (q.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_done: got done=1, expected no pending instruction");
                end else begin
                    e = q.pop_front();
                    chk("wb_write", 32'(Write_Reg), 32'(e.wr));
                    chk("wb_retired", 32'(retired), 32'(e.ret));
                    if (e.full) begin
                        chk("wb_ra", 32'(R_Addr_A), 32'(e.ra));
                        chk("wb_rb", 32'(R_Addr_B), 32'(e.rb));
                        chk("wb_wa", 32'(W_Addr), 32'(e.wa));
                        chk("wb_alu", 32'(ALU_OP), 32'(e.alu));
                        chk("wb_sel", 32'({rd_rt_s, rt_imm_s, imm_s}), 32'({e.rt, e.ri, e.is}));
                    end
                end
            end else if (Write_Reg !== 1'b0) begin
                total++;
                $display("FAIL stray_write: got Write_Reg=%b outside WB, expected 0", Write_Reg);
            end
        end
    end

    initial begin
        rst = 1'b0;
        inst_valid = 1'b0;
        inst = 32'd0;
        repeat (2) @(negedge clk);
        chk_reset();
        rst = 1'b1;
        @(negedge clk);
        // abort add $7,$1,$2 with reset during EXEC
        issue(32'h00223820, mk(0, 0, 0, 0, 0, 0, 0, 0, 0), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_reset();
        rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("abort_retired", 32'(retired), 32'd0);
        // add $3,$1,$2
        issue(32'h00221820, mk(1, 2, 3, 1, 3'b100, 0, 0, 0, 1), 1);
        chk("add_ra", 32'(R_Addr_A), 32'd1);
        chk("add_rb", 32'(R_Addr_B), 32'd2);
        chk("add_alu", 32'(ALU_OP), 32'b100);
        chk("add_wr_decode", 32'(Write_Reg), 32'd0);
        repeat (2) @(negedge clk);
        chk("add_wr_wb", 32'({Write_Reg, done}), 32'b11);
        chk("add_wa_wb", 32'(W_Addr), 32'd3);
        @(negedge clk);
        chk("add_ready_k4", 32'(inst_ready), 32'd1);
        chk("add_retired_k4", 32'(retired), 32'd1);
        // addi $5,$0,-1 then ori $6,$0,0xFFFF
        issue(32'h2005FFFF, mk(0, 5, 5, 1, 3'b100, 1, 1, 1, 1), 1);
        chk("addi_sel", 32'({rd_rt_s, rt_imm_s, imm_s}), 32'b111);
        repeat (3) @(negedge clk);
        issue(32'h3406FFFF, mk(0, 6, 6, 1, 3'b001, 1, 1, 0, 1), 1);
        chk("ori_imm_s", 32'(imm_s), 32'd0);
        chk("ori_alu", 32'(ALU_OP), 32'b001);
        repeat (3) @(negedge clk);
        // add $0,$1,$2: write suppressed, done still pulses
        issue(32'h00220020, mk(1, 2, 0, 0, 3'b100, 0, 0, 0, 1), 1);
        repeat (3) @(negedge clk);
        // inst_valid held high with a new word every cycle
        for (int i = 0; i < 12; i++) begin
            if (i % 4 == 1) chk("latched_ra", 32'(R_Addr_A), 32'(i));
            inst = {6'h00, 5'(i + 1), 5'(i + 2), 5'(i + 3), 5'd0, 6'h20};
            inst_valid = 1'b1;
            chk("stream_ready", 32'(inst_ready), 32'(i % 4 == 0));
            if (i % 4 == 0) begin
                q.push_back('{5'(i + 1), 5'(i + 2), 5'(i + 3), 1'b1, 3'b100, 1'b0, 1'b0, 1'b0, exp_ret, 1'b1});
                exp_ret++;
            end
            @(negedge clk);
        end
        inst_valid = 1'b0;
        // illegal opcode 0x3F
        issue(32'hFC000000, mk(0, 0, 0, 0, 0, 0, 0, 0, 0), 1);
        chk("illegal_set", 32'(illegal), 32'd1);
        repeat (3) @(negedge clk);
`ifdef GPR_CTRL_TRAP_EN
        repeat (2) @(negedge clk);
        chk("trap_ready", 32'(inst_ready), 32'd0);
        chk("trap_illegal", 32'(illegal), 32'd1);
`else
        chk("nop_retired", 32'(retired), 32'(exp_ret));
        issue(32'h00221820, mk(1, 2, 3, 1, 3'b100, 0, 0, 0, 1), 1);
        chk("post_ill_accept", 32'(R_Addr_A), 32'd1);
        chk("illegal_sticky", 32'(illegal), 32'd1);
        repeat (3) @(negedge clk);
        chk("post_ill_ready", 32'(inst_ready), 32'd1);
`endif
        repeat (2) @(negedge clk);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule

// File: doc/gpr_ctrl.md
GPR_CTRL -- requirements
Module: gpr_ctrl

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock, rising edge.
REQ-002 The block SHALL have the port rst, input, 1 bit: synchronous active-low reset, sampled on the rising edge of clk.
REQ-003 The block SHALL have the port inst, input, 32 bits: instruction word, MIPS R/I format.
REQ-004 The block SHALL have the port inst_valid, input, 1 bit: inst is offered.
REQ-005 The block SHALL have the port inst_ready, output, 1 bit: the controller can accept inst.
REQ-006 The block SHALL have the ports R_Addr_A and R_Addr_B, output, 5 bits each: GPR read addresses, rs and rt.
REQ-007 The block SHALL have the port W_Addr, output, 5 bits: GPR write address.
REQ-008 The block SHALL have the port Write_Reg, output, 1 bit: GPR write strobe.
REQ-009 The block SHALL have the port ALU_OP, output, 3 bits: 000 AND, 001 OR, 010 XOR, 011 NOR, 100 ADD, 101 SUB, 110 SLT, 111 SLLV.
REQ-010 The block SHALL have the ports rd_rt_s, rt_imm_s and imm_s, output, 1 bit each: 1 = write rt, 1 = B operand is immediate, 1 = sign-extend immediate.
REQ-011 The block SHALL have the port done, output, 1 bit: one-cycle retire pulse.
REQ-012 The block SHALL have the port illegal, output, 1 bit: unsupported instruction seen.
REQ-013 The block SHALL have the port retired, output, 16 bits: count of retired instructions.

Function
REQ-014 The FSM SHALL have the states IDLE, DECODE, EXEC and WB, with transitions IDLE->DECODE on inst_valid&&inst_ready, DECODE->EXEC, EXEC->WB and WB->IDLE unconditionally.
REQ-015 inst_ready SHALL be 1 only in IDLE, and inst SHALL be latched on acceptance; later changes to inst are ignored until the next IDLE.
REQ-016 Timing SHALL be as follows: accept at edge k; DECODE during k+1; EXEC during k+2; WB during k+3; inst_ready high again at k+4, giving a throughput of one instruction per 4 cycles.
REQ-017 In DECODE, EXEC and WB, all address, ALU_OP and select outputs SHALL be registered and held stable; in IDLE they SHALL hold their last value.
REQ-018 R-type decoding (op=0) SHALL map funct to ALU_OP as 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR, 0x20 ADD, 0x22 SUB, 0x2A SLT, 0x04 SLLV, with rd_rt_s=0, rt_imm_s=0, W_Addr=rd.
REQ-019 I-type decoding SHALL be: op 0x08 ADD with imm_s=1; op 0x0A SLT with imm_s=1; op 0x0C AND, 0x0D OR and 0x0E XOR with imm_s=0; all with rd_rt_s=1, rt_imm_s=1, W_Addr=rt.
REQ-020 Write_Reg SHALL be 1 only during WB, for exactly one cycle, and SHALL be forced to 0 when W_Addr=0 or the instruction is illegal.
REQ-021 done SHALL pulse for one cycle during WB for every accepted instruction, including suppressed writes.
REQ-022 retired SHALL increment by 1 on each done pulse and SHALL wrap from 0xFFFF to 0x0000.
REQ-023 An unsupported op or funct SHALL set illegal=1; illegal is sticky until reset.
REQ-024 inst_valid asserted outside IDLE SHALL be ignored, with no acceptance and no state change.

Reset
REQ-025 When rst=0 at a clock edge, the block SHALL enter IDLE and drive inst_ready=1 after the edge, with all of the following cleared: R_Addr_A, R_Addr_B, W_Addr, ALU_OP, rd_rt_s, rt_imm_s, imm_s, Write_Reg, done, illegal=0 and retired=0.
REQ-026 Reset in any state SHALL abort the current instruction, with no Write_Reg pulse and no done pulse on or after the reset edge.
REQ-027 Reset SHALL take priority over acceptance on the same edge.

Configuration
REQ-028 With macro GPR_CTRL_TRAP_EN defined, illegal=1 SHALL hold the FSM in IDLE with inst_ready=0 until reset, so no further instructions are accepted.
REQ-029 Without GPR_CTRL_TRAP_EN, an illegal instruction SHALL complete as a NOP: no write, done still pulses, retired increments, illegal still set, and acceptance continues.

Verification
REQ-030 The bench SHALL apply add $3,$1,$2 (0x00221820) with inst_valid=1 at edge k and check R_Addr_A=1, R_Addr_B=2, ALU_OP=100, Write_Reg=1 with W_Addr=3 during k+3, done=1, retired=1 and inst_ready=1 at k+4.
REQ-031 The bench SHALL apply addi $5,$0,-1 (0x2005FFFF) and check rd_rt_s=1, rt_imm_s=1, imm_s=1, ALU_OP=100, W_Addr=5; then ori $6,$0,0xFFFF (0x3406FFFF) and check imm_s=0, ALU_OP=001.
REQ-032 The bench SHALL apply add $0,$1,$2 (0x00220020) and check Write_Reg stays 0 throughout while done pulses once.
REQ-033 The bench SHALL hold inst_valid=1 continuously with changing inst and check acceptance only every 4th cycle and that the outputs reflect the latched word.
REQ-034 The bench SHALL drive rst=0 during EXEC and check no Write_Reg or done pulse, state IDLE, retired unchanged at 0, and outputs at reset values.
REQ-035 The bench SHALL apply op 0x3F and check illegal=1; with GPR_CTRL_TRAP_EN, inst_ready=0 thereafter; without it, done pulses, Write_Reg=0, and the next add is accepted.
